// File: rtl/phase_sequencer_ctrl.sv
// 8-phase instruction sequencer with internal phase counter, memory wait states,
// wait-state timeout and illegal-opcode trapping. Optional macro: CTRL_SINGLE_STEP_EN.
module phase_sequencer_ctrl #(
  parameter int unsigned OPCODE_W   = 3,
  parameter int unsigned MAX_WAIT   = 15,
  parameter int unsigned WAIT_CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                mem_ready,
`ifdef CTRL_SINGLE_STEP_EN
  input  logic                step_mode,
`endif
  output logic                sel,
  output logic                rd,
  output logic                ld_ir,
  output logic                inc_pc,
  output logic                ld_pc,
  output logic                data_c,
  output logic                ld_ac,
  output logic                wr,
  output logic                halt,
  output logic [2:0]          phase,
  output logic                busy,
  output logic                bus_err,
  output logic                illegal
);

  localparam logic [2:0] OpHlt = 3'd0;
  localparam logic [2:0] OpSkz = 3'd1;
  localparam logic [2:0] OpAdd = 3'd2;
  localparam logic [2:0] OpLda = 3'd5;
  localparam logic [2:0] OpSto = 3'd6;
  localparam logic [2:0] OpJmp = 3'd7;

  typedef enum logic [1:0] {StStopped, StRun, StHalted} state_e;

  state_e                state_q, state_d;
  logic [2:0]            phase_q, phase_d;
  logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic                  bus_err_q, bus_err_d;
  logic                  illegal_q, illegal_d;

  logic       illegal_op;
  logic [2:0] op;
  logic       is_alu, is_sto, is_jmp, is_skz, is_hlt;
  logic       mem_phase, timeout, step_stop;

  generate
    if (OPCODE_W > 3) begin : g_wide_op
      assign illegal_op = |opcode[OPCODE_W-1:3];
    end else begin : g_narrow_op
      assign illegal_op = 1'b0;
    end
  endgenerate

`ifdef CTRL_SINGLE_STEP_EN
  assign step_stop = step_mode;
`else
  assign step_stop = 1'b0;
`endif

  assign op     = opcode[2:0];
  assign is_alu = !illegal_op && (op >= OpAdd) && (op <= OpLda);
  assign is_sto = !illegal_op && (op == OpSto);
  assign is_jmp = !illegal_op && (op == OpJmp);
  assign is_skz = !illegal_op && (op == OpSkz);
  assign is_hlt = !illegal_op && (op == OpHlt);

  // Phases that wait on the memory handshake.
  assign mem_phase = (phase_q == 3'd1) || ((phase_q == 3'd5) && is_alu) ||
                     ((phase_q == 3'd7) && is_sto);
  // This stall cycle would be the MAX_WAIT-th consecutive one.
  assign timeout   = (wait_cnt_q == WAIT_CNT_W'(MAX_WAIT - 1));

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    wait_cnt_d = wait_cnt_q;
    bus_err_d  = bus_err_q;
    illegal_d  = illegal_q;
    unique case (state_q)
      StRun: begin
        if ((phase_q == 3'd4) && illegal_op) begin
          illegal_d = 1'b1;
          state_d   = StHalted;
          phase_d   = 3'd0;
        end else if ((phase_q == 3'd4) && is_hlt) begin
          state_d = StHalted;
          phase_d = 3'd0;
        end else if (mem_phase && !mem_ready) begin
          if (timeout) begin
            bus_err_d  = 1'b1;
            state_d    = StHalted;
            phase_d    = 3'd0;
            wait_cnt_d = '0;
          end else begin
            wait_cnt_d = wait_cnt_q + 1'b1;
          end
        end else begin
          wait_cnt_d = '0;
          phase_d    = phase_q + 3'd1;
          if ((phase_q == 3'd7) && step_stop) state_d = StStopped;
        end
      end
      default: begin
        // Sticky faults lock out run; only reset recovers.
        if (run && !bus_err_q && !illegal_q) begin
          state_d    = StRun;
          phase_d    = 3'd0;
          wait_cnt_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StStopped;
      phase_q    <= 3'd0;
      wait_cnt_q <= '0;
      bus_err_q  <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      wait_cnt_q <= wait_cnt_d;
      bus_err_q  <= bus_err_d;
      illegal_q  <= illegal_d;
    end
  end

  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    ld_pc  = 1'b0;
    data_c = 1'b0;
    ld_ac  = 1'b0;
    wr     = 1'b0;
    halt   = (state_q == StHalted);
    if (state_q == StRun) begin
      unique case (phase_q)
        3'd0: sel = 1'b1;
        3'd1: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        3'd2, 3'd3: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        3'd4: begin
          inc_pc = !illegal_op;
          halt   = is_hlt;
        end
        3'd5: rd = is_alu;
        3'd6: begin
          rd     = is_alu;
          inc_pc = is_skz && zero;
          ld_pc  = is_jmp;
          data_c = is_sto;
        end
        3'd7: begin
          rd     = is_alu;
          ld_ac  = is_alu;
          ld_pc  = is_jmp;
          data_c = is_sto;
          wr     = is_sto;
        end
        default: ;
      endcase
    end
  end

  assign phase   = phase_q;
  assign busy    = (state_q == StRun);
  assign bus_err = bus_err_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_phase_sequencer_ctrl.sv
// Directed bench for phase_sequencer_ctrl (OPCODE_W=4, MAX_WAIT=4); covers
// CTRL_SINGLE_STEP_EN when that macro is defined.
module tb_phase_sequencer_ctrl;

  logic       clk = 1'b0;
  logic       rst, run, zero, mem_ready;
  logic [3:0] opcode;
  logic       sel, rd, ld_ir, inc_pc, ld_pc, data_c, ld_ac, wr, halt, busy, bus_err, illegal;
  logic [2:0] phase;
`ifdef CTRL_SINGLE_STEP_EN
  logic       step_mode;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Enable byte order: {sel, rd, ld_ir, inc_pc, ld_pc, data_c, ld_ac, wr}
  localparam logic [31:0] Fetch = {8'h80, 8'hC0, 8'hE0, 8'hE0};
  localparam logic [63:0] EvAdd = {Fetch, 8'h10, 8'h40, 8'h40, 8'h42};
  localparam logic [63:0] EvSz1 = {Fetch, 8'h10, 8'h00, 8'h10, 8'h00};
  localparam logic [63:0] EvSz0 = {Fetch, 8'h10, 8'h00, 8'h00, 8'h00};
  localparam logic [63:0] EvJmp = {Fetch, 8'h10, 8'h00, 8'h08, 8'h08};
  localparam logic [63:0] EvSto = {Fetch, 8'h10, 8'h00, 8'h04, 8'h05};

  phase_sequencer_ctrl #(
    .OPCODE_W  (4),
    .MAX_WAIT  (4),
    .WAIT_CNT_W(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .opcode   (opcode),
    .zero     (zero),
    .mem_ready(mem_ready),
`ifdef CTRL_SINGLE_STEP_EN
    .step_mode(step_mode),
`endif
    .sel      (sel),
    .rd       (rd),
    .ld_ir    (ld_ir),
    .inc_pc   (inc_pc),
    .ld_pc    (ld_pc),
    .data_c   (data_c),
    .ld_ac    (ld_ac),
    .wr       (wr),
    .halt     (halt),
    .phase    (phase),
    .busy     (busy),
    .bus_err  (bus_err),
    .illegal  (illegal)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Compares {phase, busy, halt, enables}.
  task automatic chk(string tag, logic [2:0] ph, logic bsy, logic hlt, logic [7:0] en);
    logic [12:0] obs, exp;
    #1;
    obs = {phase, busy, halt, sel, rd, ld_ir, inc_pc, ld_pc, data_c, ld_ac, wr};
    exp = {ph, bsy, hlt, en};
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_flags(string tag, logic be, logic il);
    n_cmp++;
    assert ({bus_err, illegal} === {be, il}) else begin
      n_err++;
      $error("FAIL %s: observed bus_err/illegal %b%b expected %b%b", tag, bus_err, illegal, be,
             il);
    end
  endtask

  // Starts at phase 0 of the instruction; leaves after the phase-7 advance.
  task automatic do_instr(string tag, logic [3:0] op, logic z, logic [63:0] ev);
    opcode = op;
    zero   = z;
    for (int p = 0; p < 8; p++) begin
      chk(tag, 3'(p), 1'b1, 1'b0, ev[63-8*p -: 8]);
      tick();
    end
  endtask

  task automatic pulse_run();
    run = 1'b1;
    tick();
    run = 1'b0;
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; opcode = 4'd0; zero = 1'b0; mem_ready = 1'b1;
`ifdef CTRL_SINGLE_STEP_EN
    step_mode = 1'b0;
`endif
    tick();
    tick();
    chk("reset", 3'd0, 1'b0, 1'b0, 8'h00);
    chk_flags("reset_flags", 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    chk("stopped_idle", 3'd0, 1'b0, 1'b0, 8'h00);

    // Back-to-back instructions with no wait states
    opcode = 4'd2;
    pulse_run();
    do_instr("add", 4'd2, 1'b0, EvAdd);
    do_instr("skz_z1", 4'd1, 1'b1, EvSz1);
    do_instr("skz_z0", 4'd1, 1'b0, EvSz0);
    do_instr("jmp", 4'd7, 1'b0, EvJmp);
    run = 1'b1;  // ignored while running
    do_instr("sto", 4'd6, 1'b0, EvSto);
    run = 1'b0;

    // STO with three wait cycles in phase 7
    opcode = 4'd6;
    for (int p = 0; p < 7; p++) begin
      chk("sto_w", 3'(p), 1'b1, 1'b0, EvSto[63-8*p -: 8]);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 3);
      chk("sto_stall7", 3'd7, 1'b1, 1'b0, 8'h05);
      tick();
    end
    chk("sto_wrap", 3'd0, 1'b1, 1'b0, 8'h80);
    chk_flags("sto_noerr", 1'b0, 1'b0);

    // Wait-state timeout in phase 1
    opcode = 4'd2;
    tick();
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("stall_ph1", 3'd1, 1'b1, 1'b0, 8'hC0);
      tick();
    end
    chk("timeout_halted", 3'd0, 1'b0, 1'b1, 8'h00);
    chk_flags("timeout_flags", 1'b1, 1'b0);
    mem_ready = 1'b1;
    pulse_run();
    chk("run_locked_out", 3'd0, 1'b0, 1'b1, 8'h00);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_clears", 3'd0, 1'b0, 1'b0, 8'h00);
    chk_flags("rst_clears_flags", 1'b0, 1'b0);

    // HLT, then resume
    opcode = 4'd0;
    pulse_run();
    for (int p = 0; p < 4; p++) begin
      chk("hlt_fetch", 3'(p), 1'b1, 1'b0, Fetch[31-8*p -: 8]);
      tick();
    end
    chk("hlt_ph4", 3'd4, 1'b1, 1'b1, 8'h10);
    tick();
    chk("halted", 3'd0, 1'b0, 1'b1, 8'h00);
    tick();
    chk("halted_hold", 3'd0, 1'b0, 1'b1, 8'h00);
    opcode = 4'd9;
    pulse_run();
    chk("resume", 3'd0, 1'b1, 1'b0, 8'h80);

    // Illegal opcode 9
    for (int p = 1; p < 4; p++) begin
      tick();
      chk("ill_fetch", 3'(p), 1'b1, 1'b0, Fetch[31-8*p -: 8]);
    end
    tick();
    chk("ill_ph4", 3'd4, 1'b1, 1'b0, 8'h00);
    chk_flags("ill_ph4_flags", 1'b0, 1'b0);
    tick();
    chk("ill_halted", 3'd0, 1'b0, 1'b1, 8'h00);
    chk_flags("ill_flags", 1'b0, 1'b1);
    pulse_run();
    chk("ill_locked_out", 3'd0, 1'b0, 1'b1, 8'h00);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_flags("ill_rst", 1'b0, 1'b0);

    // Reset mid-instruction in phase 5
    opcode = 4'd2;
    pulse_run();
    for (int p = 0; p < 5; p++) tick();
    chk("pre_rst_ph5", 3'd5, 1'b1, 1'b0, 8'h40);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst", 3'd0, 1'b0, 1'b0, 8'h00);

`ifdef CTRL_SINGLE_STEP_EN
    step_mode = 1'b1;
    pulse_run();
    do_instr("step1", 4'd2, 1'b0, EvAdd);
    chk("step1_stop", 3'd0, 1'b0, 1'b0, 8'h00);
    tick();
    chk("step1_hold", 3'd0, 1'b0, 1'b0, 8'h00);
    pulse_run();
    do_instr("step2", 4'd7, 1'b0, EvJmp);
    chk("step2_stop", 3'd0, 1'b0, 1'b0, 8'h00);
    step_mode = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/phase_sequencer_ctrl.md
Name: phase_sequencer_ctrl

Overview:
- Parametrised successor to the 8-phase instruction controller for the accumulator CPU.
- Generates its own phase counter internally rather than taking phase as an input.
- Stretches memory phases using a mem_ready handshake, with a wait-state timeout.
- Holds a latched HALTED state and flags illegal opcodes when the opcode field is wider than 3 bits.
- Sits between the instruction register/ALU zero flag and the PC, IR, AC and memory-bus enables.

Parameters:
- OPCODE_W, 3: opcode field width. Must be >= 3. Values 8 and above are illegal.
- MAX_WAIT, 15: maximum number of consecutive mem_ready=0 cycles tolerated in a memory phase before bus error. Range 1..255.
- WAIT_CNT_W, 8: width of the wait counter. Must satisfy 2**WAIT_CNT_W > MAX_WAIT.

Ports:
- clk, in, 1: clock; all state updates on the rising edge.
- rst, in, 1: synchronous, active-high reset.
- run, in, 1: start/resume request, sampled while STOPPED or HALTED.
- opcode, in, OPCODE_W: current IR opcode; must be stable from phase 3 onward.
- zero, in, 1: accumulator-zero flag.
- mem_ready, in, 1: memory completes the current rd/wr this cycle.
- sel, rd, ld_ir, inc_pc, ld_pc, data_c, ld_ac, wr, out, 1 each: datapath enables.
- halt, out, 1: asserted in phase 4 of HLT and throughout HALTED.
- phase, out, 3: current phase, 0..7.
- busy, out, 1: 1 while in RUN.
- bus_err, out, 1: sticky; set on wait-state timeout.
- illegal, out, 1: sticky; set on opcode >= 8.

Behaviour:
- States:
  - STOPPED: reset state.
  - RUN: phase advances 0..7.
  - HALTED.
- Reset values: state=STOPPED, phase=0, wait counter=0, bus_err=0, illegal=0. All enables, halt and busy are 0.
- Transitions out of STOPPED/HALTED:
  - On run=1, go to RUN at phase 0 on the next edge.
  - If bus_err or illegal is set, run is ignored; only rst clears.
- In RUN, phase increments by 1 per cycle, wrapping from 7 to 0, except in the stall conditions below.
- Opcodes: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7. ALUOP = ADD, AND, XOR, LDA.
- Enables are combinational from the registered phase and state plus opcode/zero. They are valid in the same cycle as phase. Per phase:
  - Phase 0: sel.
  - Phase 1: sel, rd.
  - Phase 2: sel, rd, ld_ir.
  - Phase 3: sel, rd, ld_ir.
  - Phase 4: inc_pc. halt if HLT.
  - Phase 5: rd if ALUOP.
  - Phase 6: rd if ALUOP. inc_pc if SKZ and zero. ld_pc if JMP. data_c if STO.
  - Phase 7: rd and ld_ac if ALUOP. ld_pc if JMP. data_c and wr if STO.
- Wait states:
  - Applies in phase 1, in phase 5 when ALUOP, and in phase 7 when STO.
  - Phase holds while mem_ready=0, and the wait counter increments.
  - The phase advances on the cycle mem_ready=1; the counter clears.
  - Enables stay asserted during the stall. inc_pc and ld_pc are never asserted in a stalled phase.
- Timeout: when the counter reaches MAX_WAIT with mem_ready still 0, set bus_err, go to HALTED and drop all enables. halt=1.
- HLT: phase 4 asserts inc_pc and halt for one cycle, then the next state is HALTED with phase=0.
- Illegal opcode: in phase 4, if opcode >= 8, set illegal, go to HALTED and suppress inc_pc.
- HALTED: halt=1, all other enables 0, busy=0.
- Simultaneous events: rst overrides everything. run asserted while in RUN is ignored. A stall plus timeout in the same cycle means timeout wins.
- Reset mid-instruction: returns to STOPPED with phase=0 on the next edge. No enable remains asserted after that edge.

Optional Feature:
- CTRL_SINGLE_STEP_EN
- Defined:
  - Adds input port step_mode (1 bit).
  - When step_mode=1, completing phase 7 returns to STOPPED (busy=0, halt=0) instead of wrapping.
  - The next run pulse executes exactly one more instruction.
  - step_mode is sampled at the phase-7 advance.
- Undefined: the port is absent and RUN wraps continuously from 7 to 0.

Test Plan:
- Reset, then run=1 for 1 cycle, opcode=2 (ADD), mem_ready=1 -> phase sequence 0..7 with no stalls. ld_ac=1 only in phase 7. inc_pc=1 only in phase 4. busy=1.
- opcode=1 (SKZ) with zero=1 -> inc_pc=1 in phases 4 and 6. With zero=0 -> inc_pc only in phase 4. opcode=7 (JMP) -> ld_pc=1 in phases 6 and 7.
- opcode=6 (STO), mem_ready=0 for 3 cycles in phase 7 -> phase holds at 7 for 4 cycles with wr=1 and data_c=1, then wraps to 0.
- MAX_WAIT=4, mem_ready held 0 in phase 1 -> bus_err=1 and halt=1 after 4 stall cycles. A later run=1 has no effect; rst clears bus_err.
- opcode=0 (HLT) -> halt=1 in phase 4, then HALTED with halt=1. run=1 -> resumes at phase 0, busy=1. OPCODE_W=4 with opcode=9 -> illegal=1, no inc_pc.
- With CTRL_SINGLE_STEP_EN and step_mode=1 -> after one instruction, state is STOPPED with busy=0. Each run pulse yields exactly 8 phases. Assert rst in phase 5 -> phase=0 and all enables 0 on the next edge.
